// File: rtl/cr_xer_unit_if.sv
// cr_xer_unit_if: writeback commit bundle into the CR/XER unit
// plus the CR/XER read-back paths toward the ALU and branch logic.
interface cr_xer_unit_if #(
    parameter int CR_FIELDS    = 8,
    parameter int XER_BC_WIDTH = 7
);
    logic                       wb_valid;
    logic                       flush;
    logic [0:7]                 alu_d;
    logic                       ca_we;
    logic                       oe;
    logic                       rc;
    logic                       cmp_we;
    logic [2:0]                 crfd;
    logic [1:0]                 mt_op;
    logic [CR_FIELDS-1:0]       fxm;
    logic [0:31]                mt_data;
    logic [0:4*CR_FIELDS-1]     cr_rd;
    logic [0:31]                xer_rd;

    modport master (
        output wb_valid, flush, alu_d, ca_we, oe, rc, cmp_we,
        output crfd, mt_op, fxm, mt_data,
        input  cr_rd, xer_rd
    );

    modport slave (
        input  wb_valid, flush, alu_d, ca_we, oe, rc, cmp_we,
        input  crfd, mt_op, fxm, mt_data,
        output cr_rd, xer_rd
    );
endinterface

// File: rtl/cr_xer_unit.sv
// cr_xer_unit: architectural CR/XER state and commit stage after the ALU.
// Optional macro CR_XER_BYPASS_EN forwards next-state onto cr_rd/xer_rd.
module cr_xer_unit #(
    parameter int CR_FIELDS    = 8,
    parameter int XER_BC_WIDTH = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    cr_xer_unit_if.slave bus
);
    localparam int CRW = 4 * CR_FIELDS;

    logic [0:CRW-1]          cr_q, cr_d;
    logic                    so_q, so_d;
    logic                    ov_q, ov_d;
    logic                    ca_q, ca_d;
    logic [0:XER_BC_WIDTH-1] bc_q, bc_d;

    logic                    commit;
    logic                    so_new;
    logic [4:0]              fidx;
    logic [0:31]             xer_q, xer_d;

    assign commit = bus.wb_valid & ~bus.flush;
    assign so_new = so_q | (bus.oe & bus.alu_d[1]);
    assign fidx   = {bus.crfd, 2'b00};

    // Next-state: mt_op takes priority, otherwise apply enabled ALU flags
    always_comb begin
        cr_d = cr_q;
        so_d = so_q;
        ov_d = ov_q;
        ca_d = ca_q;
        bc_d = bc_q;
        if (commit) begin
            unique case (bus.mt_op)
                2'b01: begin
                    for (int i = 0; i < CR_FIELDS; i++) begin
                        if (bus.fxm[i]) begin
                            cr_d[4*i +: 4] = bus.mt_data[4*i +: 4];
                        end
                    end
                end
                2'b10: begin
                    so_d = bus.mt_data[0];
                    ov_d = bus.mt_data[1];
                    ca_d = bus.mt_data[2];
                    bc_d = bus.mt_data[32-XER_BC_WIDTH +: XER_BC_WIDTH];
                end
                2'b11: begin
                    cr_d[fidx +: 4] = {so_q, ov_q, ca_q, 1'b0};
                    so_d = 1'b0;
                    ov_d = 1'b0;
                    ca_d = 1'b0;
                end
                default: begin
                    if (bus.oe) begin
                        ov_d = bus.alu_d[1];
                        so_d = so_new;
                    end
                    if (bus.ca_we) begin
                        ca_d = bus.alu_d[0];
                    end
                    if (bus.rc) begin
                        cr_d[0:3] = {bus.alu_d[2:4], so_new};
                    end
                    // Written after CR0 so a compare to field 0 wins
                    if (bus.cmp_we) begin
                        cr_d[fidx +: 4] = {bus.alu_d[5:7], so_new};
                    end
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cr_q <= '0;
            so_q <= 1'b0;
            ov_q <= 1'b0;
            ca_q <= 1'b0;
            bc_q <= '0;
        end else begin
            cr_q <= cr_d;
            so_q <= so_d;
            ov_q <= ov_d;
            ca_q <= ca_d;
            bc_q <= bc_d;
        end
    end

    assign xer_q = {so_q, ov_q, ca_q, {(29-XER_BC_WIDTH){1'b0}}, bc_q};
    assign xer_d = {so_d, ov_d, ca_d, {(29-XER_BC_WIDTH){1'b0}}, bc_d};

`ifdef CR_XER_BYPASS_EN
    // Forward next-state so a same-cycle commit is seen immediately
    assign bus.cr_rd  = rst_n ? cr_d  : '0;
    assign bus.xer_rd = rst_n ? xer_d : '0;
`else
    assign bus.cr_rd  = cr_q;
    assign bus.xer_rd = xer_q;
`endif

endmodule

// File: tb/tb_cr_xer_unit.sv
// tb_cr_xer_unit: scoreboard bench for cr_xer_unit (directed plan steps
// followed by a random commit stream checked against a reference model).
module tb_cr_xer_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cr_xer_unit_if bus ();

    cr_xer_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] cr;
        logic [31:0] xer;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [0:31] m_cr  = '0;
    logic [0:31] m_xer = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic fl, input logic [7:0] d,
                       input logic ca, input logic o, input logic r,
                       input logic c, input logic [2:0] f,
                       input logic [1:0] op, input logic [7:0] m,
                       input logic [31:0] data);
        bus.wb_valid = v;
        bus.flush    = fl;
        bus.alu_d    = d;
        bus.ca_we    = ca;
        bus.oe       = o;
        bus.rc       = r;
        bus.cmp_we   = c;
        bus.crfd     = f;
        bus.mt_op    = op;
        bus.fxm      = m;
        bus.mt_data  = data;
    endtask

    // Reference model of one clock edge using the current bus inputs
    task automatic model_step();
        logic so_n;
        logic [0:31] ox;
        if (!rst_n) begin
            m_cr  = '0;
            m_xer = '0;
        end else if (bus.wb_valid && !bus.flush) begin
            ox = m_xer;
            case (bus.mt_op)
                2'd1: begin
                    for (int f = 0; f < 8; f++)
                        if (bus.fxm[f])
                            for (int b = 0; b < 4; b++)
                                m_cr[4*f+b] = bus.mt_data[4*f+b];
                end
                2'd2: m_xer = bus.mt_data & 32'hE000_007F;
                2'd3: begin
                    for (int b = 0; b < 4; b++)
                        m_cr[4*int'(bus.crfd)+b] = ox[b];
                    m_xer = ox & 32'h1FFF_FFFF;
                end
                default: begin
                    so_n = ox[0] | (bus.oe & bus.alu_d[1]);
                    if (bus.oe) begin
                        m_xer[1] = bus.alu_d[1];
                        m_xer[0] = so_n;
                    end
                    if (bus.ca_we) m_xer[2] = bus.alu_d[0];
                    if (bus.rc) begin
                        m_cr[0] = bus.alu_d[2];
                        m_cr[1] = bus.alu_d[3];
                        m_cr[2] = bus.alu_d[4];
                        m_cr[3] = so_n;
                    end
                    if (bus.cmp_we) begin
                        m_cr[4*int'(bus.crfd)+0] = bus.alu_d[5];
                        m_cr[4*int'(bus.crfd)+1] = bus.alu_d[6];
                        m_cr[4*int'(bus.crfd)+2] = bus.alu_d[7];
                        m_cr[4*int'(bus.crfd)+3] = so_n;
                    end
                end
            endcase
        end
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_cr"}, bus.cr_rd, e.cr);
            chk({e.tag, "_xer"}, bus.xer_rd, e.xer);
        end
    endtask

    task automatic clock_and_check();
`ifdef CR_XER_BYPASS_EN
        #1;
        sample();
        @(posedge clk);
        #1;
`else
        @(posedge clk);
        #1;
        sample();
`endif
    endtask

    // Directed step: expectation is a fixed constant, model is resynced
    task automatic go_exp(input string tag, input logic [31:0] ecr,
                          input logic [31:0] exr);
        exp_t e;
        m_cr  = ecr;
        m_xer = exr;
        e.tag = tag;
        e.cr  = ecr;
        e.xer = exr;
        sb.push_back(e);
        clock_and_check();
    endtask

    task automatic go_model(input string tag);
        exp_t e;
        model_step();
        e.tag = tag;
        e.cr  = m_cr;
        e.xer = m_xer;
        sb.push_back(e);
        clock_and_check();
    endtask

    initial begin
        drv(0, 0, 8'h00, 0, 0, 0, 0, 3'd0, 2'd0, 8'h00, 32'h0);
        rst_n = 1'b0;
        go_exp("reset", 32'h0, 32'h0);
        rst_n = 1'b1;

        drv(1, 0, 8'b0110_0000, 0, 1, 1, 0, 3'd0, 2'd0, 8'h00, 32'h0);
        go_exp("ov_rc", 32'h9000_0000, 32'hC000_0000);

        drv(1, 0, 8'b0000_0000, 1, 1, 0, 0, 3'd0, 2'd0, 8'h00, 32'h0);
        go_exp("so_sticky", 32'h9000_0000, 32'h8000_0000);

        drv(1, 0, 8'b0000_0001, 0, 0, 0, 1, 3'd3, 2'd0, 8'h00, 32'h0);
        go_exp("cmp3", 32'h9003_0000, 32'h8000_0000);

        drv(1, 0, 8'b0010_0001, 0, 0, 1, 1, 3'd0, 2'd0, 8'h00, 32'h0);
        go_exp("cmp_wins", 32'h3003_0000, 32'h8000_0000);

        drv(1, 0, 8'h00, 0, 0, 0, 0, 3'd0, 2'd1, 8'h01, 32'h9000_0000);
        go_exp("mtcrf_f0", 32'h9003_0000, 32'h8000_0000);

        drv(1, 0, 8'h00, 0, 0, 0, 0, 3'd7, 2'd3, 8'h00, 32'h0);
        go_exp("mcrxr", 32'h9003_0008, 32'h0000_0000);

        drv(1, 0, 8'h00, 0, 0, 0, 0, 3'd0, 2'd1, 8'h81, 32'h1234_5678);
        go_exp("mtcrf81", 32'h1003_0008, 32'h0000_0000);

        drv(1, 0, 8'h00, 1, 0, 0, 0, 3'd0, 2'd2, 8'h00, 32'hFFFF_FFFF);
        go_exp("mtxer_prio", 32'h1003_0008, 32'hE000_007F);

        drv(1, 1, 8'hFF, 1, 1, 1, 1, 3'd2, 2'd0, 8'hFF, 32'h0);
        go_exp("flush", 32'h1003_0008, 32'hE000_007F);

        drv(0, 0, 8'h00, 1, 1, 1, 1, 3'd2, 2'd1, 8'hFF, 32'h0);
        go_exp("no_valid", 32'h1003_0008, 32'hE000_007F);

        drv(1, 0, 8'hFF, 1, 1, 1, 1, 3'd4, 2'd0, 8'h00, 32'h0);
        go_exp("alu_all", 32'hF003_F008, 32'hE000_007F);

        rst_n = 1'b0;
        drv(1, 0, 8'hFF, 1, 1, 1, 1, 3'd5, 2'd2, 8'hFF, 32'hFFFF_FFFF);
        go_exp("rst_mid", 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int n = 0; n < 80; n++) begin
            drv($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 3'($urandom), 2'($urandom), 8'($urandom),
                $urandom);
            rst_n = (n != 40);
            go_model("rand");
        end
        rst_n = 1'b1;

        if (sb.size() != 0) chk("sb_left", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", total, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cr_xer_unit.md
Name: cr_xer_unit

Overview:
- Architectural CR/XER state holder and commit stage sitting directly downstream of the ALU.
- Consumes the ALU flag bundle D (CA, OV, CR0 LT/GT/EQ, CRX LT/GT/EQ) at writeback and applies sticky-SO semantics.
- Also executes mtcrf / mtxer / mcrxr.
- Feeds XER back to the ALU (XERrd, for adde/subfe) and exposes CR to branch/mfcr logic.

Parameters:
- CR_FIELDS, 8, number of 4-bit CR fields (CR width = 4*CR_FIELDS = 32)
- XER_BC_WIDTH, 7, width of the XER byte-count field (XER bits 25:31)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- wb_valid  in  1  an instruction commits this cycle
- flush  in  1  kill the committing instruction; no state change
- alu_d  in  8  ALU D bundle, big-endian [0:7]: [0]=CA, [1]=OV, [2:4]=CR0 LT/GT/EQ, [5:7]=CRX LT/GT/EQ
- ca_we  in  1  write XER.CA from alu_d[0]
- oe  in  1  OE form: write XER.OV from alu_d[1], OR into SO
- rc  in  1  Rc form: update CR0
- cmp_we  in  1  compare result to CR field crfd
- crfd  in  3  target CR field for cmp/mcrxr
- mt_op  in  2  00 none, 01 mtcrf, 10 mtxer, 11 mcrxr
- fxm  in  8  mtcrf field mask, fxm[i] selects CR field i
- mt_data  in  32  GPR source for mtcrf/mtxer
- cr_rd  out  32  current CR, [0:31]
- xer_rd  out  32  current XER, [0:31]: [0]=SO, [1]=OV, [2]=CA, [25:31]=byte count, rest 0

Behaviour:
- Reset (rst_n=0 at clk edge): CR=0, XER=0; cr_rd=0, xer_rd=0. Reset overrides every other input, including mid-sequence.
- Commit = wb_valid & ~flush. No commit -> all state holds.
- CR field i occupies bits 4i..4i+3 = {LT, GT, EQ, SO}.
- Commit with mt_op!=00: the mt_op is executed; ca_we/oe/rc/cmp_we are ignored.
  - mtcrf: for every i with fxm[i]=1, CR field i <= mt_data[4i:4i+3]; other fields hold.
  - mtxer: XER <= mt_data with only bits 0,1,2,25:31 kept; all other bits are forced to 0.
  - mcrxr: CR[crfd] <= XER[0:3]; XER[0:2] <= 0 in the same edge; byte count holds.
- Commit with mt_op=00 (ALU commit):
  - so_new = XER.SO | (oe & alu_d[1]).
  - oe=1: XER.OV <= alu_d[1], XER.SO <= so_new. SO is sticky and is cleared only by reset, mtxer or mcrxr.
  - ca_we=1: XER.CA <= alu_d[0].
  - rc=1: CR0 <= {alu_d[2:4], so_new}.
  - cmp_we=1: CR[crfd] <= {alu_d[5:7], so_new}.
  - rc=1 and cmp_we=1 with crfd=0: the cmp value wins.
  - Flags not enabled hold.
- Latency: without bypass, a committed update is visible on cr_rd/xer_rd in the cycle after the commit edge.
- Back-to-back commits are supported every cycle, with no stall.

Optional Feature:
- Macro: CR_XER_BYPASS_EN
- Defined: cr_rd/xer_rd present the combinational next-state, so a same-cycle commit is visible to the ALU/branch the same cycle (zero-latency forwarding for adde after addc). During the reset cycle the outputs are forced to 0.
- Undefined: cr_rd/xer_rd are driven directly from the state registers (one-cycle visibility).

Test Plan (no bypass):
- 1. Reset, then commit alu_d=8'b0110_0000, oe=1, rc=1 -> next cycle xer_rd=32'hC000_0000, cr_rd=32'h9000_0000.
- 2. Next commit alu_d=8'b0000_0000, oe=1, ca_we=1, rc=0 -> xer_rd=32'h8000_0000 (OV cleared, SO sticky), cr_rd unchanged.
- 3. Commit cmp_we=1, crfd=3, alu_d=8'b0000_0001 -> cr_rd=32'h9003_0000. Repeat with rc=1, crfd=0, alu_d=8'b0010_0001 -> CR0 takes 4'b0011.
- 4. From XER=32'h8000_0000, CR=32'h9003_0000: mt_op=11, crfd=7 -> cr_rd=32'h9003_0008, xer_rd=32'h0000_0000. Then mtcrf, fxm=8'h81, mt_data=32'h1234_5678 -> cr_rd=32'h1003_0008.
- 5. mtxer mt_data=32'hFFFF_FFFF -> xer_rd=32'hE000_007F. Same cycle ca_we=1, alu_d[0]=0 -> still 32'hE000_007F (mt_op priority).
- 6. Commit with flush=1 (any flags) -> no change. Assert rst_n=0 during a commit stream -> CR=XER=0 the next cycle regardless of inputs. Rerun 1-2 with CR_XER_BYPASS_EN -> the values appear in the commit cycle.
